// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and widths.
package uart_pkg;

   localparam int UART_DW = 8;
   localparam int CH_ID_W = 3;

   // Two-bit encoding leaves spare codes; any of them recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_OFFER = 2'b01
   } state_e;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module uart_rr_arb #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_CH producers: one-entry holding register per
// channel, round-robin selection, and an offer held on TxEn until the UART permits it.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DW     = UART_DW
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [NUM_CH-1:0]    ReqValid,
   input  logic [NUM_CH*DW-1:0] ReqData,
   output logic [NUM_CH-1:0]    ReqReady,
   input  logic [NUM_CH-1:0]    ChEnable,
   output logic [DW-1:0]        TxData,
   output logic                 TxEn,
   input  logic                 TxPermit,
   output logic                 TxAccept,
   output logic [CH_ID_W-1:0]   TxChId,
   output logic [NUM_CH-1:0]    Pending,
   output state_e               StateDbg
);

   localparam int PTR_W = $clog2(NUM_CH);

   // Handshakes: a producer byte transfers on a clock edge where ReqValid[i] & ReqReady[i];
   // the UART takes the offer on an edge where TxEn & TxPermit. ReqReady is a pure flop
   // output, and TxEn never drops until that second handshake completes.
   logic [NUM_CH-1:0][DW-1:0] hold_q, hold_d;
   logic [NUM_CH-1:0]         pend_q, pend_d;
   state_e                    state_q, state_d;
   logic [PTR_W-1:0]          ptr_q, ptr_d;
   logic [PTR_W-1:0]          win_q, win_d;
   logic [DW-1:0]             data_q, data_d;

   logic [NUM_CH-1:0] cap;
   logic              accept;
   logic [NUM_CH-1:0] arb_req;
   logic [NUM_CH-1:0] arb_gnt;
   logic [PTR_W-1:0]  arb_idx;
   logic              arb_any;

   assign cap     = ReqValid & ~pend_q;
   assign accept  = (state_q == ST_OFFER) & TxPermit;
   assign arb_req = pend_q & ChEnable;

   uart_rr_arb #(
      .N  (NUM_CH),
      .IW (PTR_W)
   ) u_arb (
      .req (arb_req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      hold_d  = hold_q;
      pend_d  = pend_q | cap;
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      data_d  = data_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cap[i]) begin
            hold_d[i] = ReqData[i*DW +: DW];
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               win_d   = arb_idx;
               data_d  = hold_q[arb_idx];
               state_d = ST_OFFER;
            end
         end
         ST_OFFER: begin
            // ChEnable is deliberately ignored here: an offer is never withdrawn.
            if (TxPermit) begin
               pend_d[win_q] = 1'b0;
               ptr_d         = (win_q == PTR_W'(NUM_CH - 1)) ? '0 : win_q + PTR_W'(1);
               state_d       = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         hold_q  <= '0;
         pend_q  <= '0;
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         data_q  <= '0;
      end else begin
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         data_q  <= data_d;
      end
   end

   assign ReqReady = ~pend_q;
   assign TxEn     = (state_q == ST_OFFER);
   assign TxData   = data_q;
   assign TxAccept = accept;
   assign TxChId   = CH_ID_W'(win_q);
   assign Pending  = pend_q;
   assign StateDbg = state_q;

endmodule
